// File: rtl/minterm_scanner.sv
// Stimulus/response scanner for a 4-input combinational function (A,B,C,D -> F).
// On start it walks all 16 input combinations, holds each for SETTLE_CYCLES cycles,
// samples F at the edge ending each vector window, builds the 16-bit truth table and
// compares it against EXPECTED_MASK.
//
// Optional build macro: SCAN_GRAY_EN -- walk the vectors in 4-bit Gray order so only
// one stimulus bit toggles per step. Results stay indexed by minterm number.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             begin a scan (accepted only when idle)
//   abort             synchronous abort of a scan in progress
//   f_in              F output of the function under test
//   a, b, c, d        stimulus, {a,b,c,d} = minterm index (a is MSB)
//   busy              high while vectors are being driven
//   done              one-cycle pulse at scan completion
//   result_valid      results below hold a completed scan
//   truth_table       captured F per minterm
//   pass              truth_table == EXPECTED_MASK
//   mismatch_count    number of differing minterms (0..16)
//   first_mismatch    lowest differing minterm, 0 when there is none
module minterm_scanner #(
  parameter logic [15:0] EXPECTED_MASK = 16'hDF03,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        f_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        result_valid,
  output logic [15:0] truth_table,
  output logic        pass,
  output logic [4:0]  mismatch_count,
  output logic [3:0]  first_mismatch
);

  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  pos_q, pos_d;     // scan position, 0..15
  logic [7:0]  cnt_q, cnt_d;     // settle counter
  logic [15:0] tt_q, tt_d;
  logic [4:0]  mm_q, mm_d;
  logic [3:0]  first_q, first_d;
  logic        pass_q, pass_d;
  logic        rv_q, rv_d;
  logic [3:0]  minterm;
  logic [3:0]  stim;

  // Scan position to minterm number; the last position (15) maps to the last vector
  // in both orders (15 ascending, 8 in Gray).
`ifdef SCAN_GRAY_EN
  assign minterm = pos_q ^ (pos_q >> 1);
`else
  assign minterm = pos_q;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StSettle;
      StSettle: begin
        if (abort) begin
          state_d = StIdle;
        end else if (cnt_q == SettleLast) begin
          state_d = StSample;
        end
      end
      StSample: begin
        if (abort) begin
          state_d = StIdle;
        end else if (pos_q == 4'hF) begin
          state_d = StDone;
        end else begin
          state_d = StSettle;
        end
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    stim = 4'h0;
    unique case (state_q)
      StSettle, StSample: begin
        busy = 1'b1;
        stim = minterm;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign {a, b, c, d}   = stim;
  assign truth_table    = tt_q;
  assign pass           = pass_q;
  assign mismatch_count = mm_q;
  assign first_mismatch = first_q;
  assign result_valid   = rv_q;

  // Datapath next-state
  always_comb begin
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    mm_d    = mm_q;
    first_d = first_q;
    pass_d  = pass_q;
    rv_d    = rv_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          pos_d   = 4'h0;
          cnt_d   = 8'h0;
          tt_d    = 16'h0;
          mm_d    = 5'h0;
          first_d = 4'h0;
          pass_d  = 1'b0;
          rv_d    = 1'b0;
        end
      end
      StSettle: begin
        if (abort || cnt_q == SettleLast) begin
          cnt_d = 8'h0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (abort) pos_d = 4'h0;
      end
      StSample: begin
        if (abort) begin
          pos_d = 4'h0;
        end else begin
          tt_d[minterm] = f_in;
          if (f_in != EXPECTED_MASK[minterm]) begin
            mm_d = mm_q + 5'd1;
            // Gray order visits minterms out of sequence, so keep the minimum.
            if (mm_q == 5'd0 || minterm < first_q) first_d = minterm;
          end
          pos_d = pos_q + 4'd1;  // wraps to 0 after the last vector
        end
      end
      StDone: begin
        rv_d   = 1'b1;
        pass_d = (tt_q == EXPECTED_MASK);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q   <= 4'h0;
      cnt_q   <= 8'h0;
      tt_q    <= 16'h0;
      mm_q    <= 5'h0;
      first_q <= 4'h0;
      pass_q  <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      mm_q    <= mm_d;
      first_q <= first_d;
      pass_q  <= pass_d;
      rv_q    <= rv_d;
    end
  end

endmodule

// File: tb/tb_minterm_scanner.sv
// Self-checking bench for minterm_scanner: a function-under-test table drives f_in from
// the DUT stimulus, a timeline model predicts every output each cycle, and directed
// scans pin the model with hand-computed results.
module tb_minterm_scanner;

  localparam logic [15:0] MASK   = 16'hDF03;
  localparam int          SETTLE = 1;
  localparam int          W      = SETTLE + 1;  // cycles per vector window
  localparam int          SCAN   = 16 * W;      // busy cycles per scan

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] func = MASK;
  logic        f_in;
  logic        a, b, c, d, busy, done, result_valid, pass;
  logic [15:0] truth_table;
  logic [4:0]  mismatch_count;
  logic [3:0]  first_mismatch;

  int checks = 0;
  int errors = 0;

  minterm_scanner #(
    .EXPECTED_MASK(MASK),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .f_in           (f_in),
    .a              (a),
    .b              (b),
    .c              (c),
    .d              (d),
    .busy           (busy),
    .done           (done),
    .result_valid   (result_valid),
    .truth_table    (truth_table),
    .pass           (pass),
    .mismatch_count (mismatch_count),
    .first_mismatch (first_mismatch)
  );

  // Function under test: a lookup table indexed by the stimulus.
  assign f_in = func[{a, b, c, d}];

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int order(input int p);
`ifdef SCAN_GRAY_EN
    return p ^ (p >> 1);
`else
    return p;
`endif
  endfunction

  function automatic int lowest(input logic [15:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 16; i++) if (v[i] && r < 0) r = i;
    return (r < 0) ? 0 : r;
  endfunction

  // Timeline model: m_k = -1 idle, 0..SCAN-1 cycles into a scan, SCAN = done cycle.
  int          m_k;
  logic [15:0] m_acc, m_tt;
  logic        m_rv, m_pass;
  int          m_cnt, m_first;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k     <= -1;
      m_acc   <= '0;
      m_tt    <= '0;
      m_rv    <= 1'b0;
      m_pass  <= 1'b0;
      m_cnt   <= 0;
      m_first <= 0;
    end else if (m_k < 0) begin
      if (start) begin
        m_k   <= 0;
        m_acc <= '0;
        m_rv  <= 1'b0;
      end
    end else if (m_k < SCAN) begin
      if (abort) begin
        m_k <= -1;
      end else begin
        if (m_k % W == W - 1) m_acc[order(m_k / W)] <= func[order(m_k / W)];
        m_k <= m_k + 1;
      end
    end else begin
      m_k     <= -1;
      m_rv    <= 1'b1;
      m_tt    <= m_acc;
      m_pass  <= (m_acc == MASK);
      m_cnt   <= $countones(m_acc ^ MASK);
      m_first <= lowest(m_acc ^ MASK);
    end
  end

  logic [3:0] prev_stim = 4'h0;

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    chk("stim", int'({a, b, c, d}), (m_k >= 0 && m_k < SCAN) ? order(m_k / W) : 0);
    chk("busy", int'(busy), int'(m_k >= 0 && m_k < SCAN));
    chk("done", int'(done), int'(m_k == SCAN));
    chk("result_valid", int'(result_valid), int'(m_rv));
    if (m_rv || !rst_n) begin
      chk("truth_table", int'(truth_table), int'(m_tt));
      chk("pass", int'(pass), int'(m_pass));
      chk("mismatch_count", int'(mismatch_count), m_cnt);
      chk("first_mismatch", int'(first_mismatch), m_first);
    end
`ifdef SCAN_GRAY_EN
    if (m_k > 0 && m_k < SCAN && m_k % W == 0)
      chk("gray_step", $countones({a, b, c, d} ^ prev_stim), 1);
`endif
    prev_stim <= {a, b, c, d};
  end

  // Pulse start, then wait (bounded) for done while counting busy cycles.
  task automatic run_scan(output int busy_n);
    bit got;
    busy_n = 0;
    got = 0;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    for (int i = 0; i < SCAN + 10 && !got; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) got = 1;
    end
    if (!got) chk("done_timeout", 0, 1);
    @(posedge clk); #2;
  endtask

  task automatic check_results(input string tag, input int tt, input int ps, input int cnt,
                               input int first);
    chk({tag, "_tt"}, int'(truth_table), tt);
    chk({tag, "_pass"}, int'(pass), ps);
    chk({tag, "_cnt"}, int'(mismatch_count), cnt);
    chk({tag, "_first"}, int'(first_mismatch), first);
    chk({tag, "_rv"}, int'(result_valid), 1);
  endtask

  initial begin
    int n;
    int dones;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    func = MASK;
    run_scan(n);
    chk("busy_len", n, 32);
    check_results("model_ok", 'hDF03, 1, 0, 0);

    func = 16'h0000;
    run_scan(n);
    check_results("tied0", 'h0000, 0, 9, 0);

    func = 16'hFFFF;
    run_scan(n);
    check_results("tied1", 'hFFFF, 0, 7, 2);

    func = 16'hFF03;
    run_scan(n);
    check_results("flip13", 'hFF03, 0, 1, 13);

    // start held high: back-to-back scans with one idle cycle between them
    func = MASK;
    dones = 0;
    @(posedge clk); #2 start = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    start = 1'b0;
    chk("held_dones", dones, 2);
    @(posedge clk); #2 abort = 1'b1;
    @(posedge clk); #2 abort = 1'b0;
    repeat (3) @(posedge clk);

    // abort while scan position 7 is driven
    #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (14) @(posedge clk);
    #2 abort = 1'b1;
    @(posedge clk); #2 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_stim", int'({a, b, c, d}), 0);
    chk("abort_rv", int'(result_valid), 0);
    dones = 0;
    for (int i = 0; i < SCAN + 8; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);

    // asynchronous reset during scan position 4
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_stim", int'({a, b, c, d}), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rv", int'(result_valid), 0);
    chk("rst_tt", int'(truth_table), 0);
    chk("rst_cnt", int'(mismatch_count), 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // randomized traffic checked by the per-cycle model
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      start = ($urandom_range(0, 9) == 0);
      abort = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 79) == 0) begin
        case ($urandom_range(0, 2))
          0:       func = 16'($urandom);
          1:       func = MASK;
          default: func = MASK ^ (16'h1 << $urandom_range(0, 15));
        endcase
      end
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (SCAN + 5) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1);
  end

endmodule

// File: doc/minterm_scanner.md
Name: minterm_scanner

Overview:
- Sequential stimulus/response engine for the 4-input combinational function blocks (inputs A,B,C,D; output F).
- On start, drives all 16 input combinations onto the function-under-test, samples F for each, and assembles the 16-bit truth table.
- Compares the result against an expected minterm mask and reports pass/fail, mismatch count and lowest mismatching minterm.
- Sits beside the function block as its driver/reader in self-check and bring-up builds.

Parameters:
- EXPECTED_MASK, 16'hDF03, expected truth table; bit i = F for minterm i (minterms 0,1,8,9,10,11,12,14,15).
- SETTLE_CYCLES, 1, cycles each vector is held before F is sampled; legal range 1..255.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  begin scan; accepted only in IDLE.
- abort  input  1  synchronous abort of a scan in progress.
- f_in  input  1  F output of the function-under-test.
- a  output  1  stimulus A, minterm bit 3 (MSB).
- b  output  1  stimulus B, minterm bit 2.
- c  output  1  stimulus C, minterm bit 1.
- d  output  1  stimulus D, minterm bit 0 (LSB).
- busy  output  1  high while scanning.
- done  output  1  one-cycle pulse at scan completion.
- result_valid  output  1  results below hold a completed scan.
- truth_table  output  16  captured F per minterm.
- pass  output  1  truth_table == EXPECTED_MASK.
- mismatch_count  output  5  number of differing minterms, 0..16.
- first_mismatch  output  4  lowest differing minterm index; 0 when mismatch_count = 0.

Behaviour:
- Reset (rst_n low, asynchronous): every output 0, FSM to IDLE, index and settle counter 0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: a/b/c/d = 0, busy = 0.
  - start = 1 at an edge: clear truth_table, pass, mismatch_count, first_mismatch and result_valid; set idx = 0; go to SETTLE.
- SETTLE: {a,b,c,d} = idx; busy = 1; hold for SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: {a,b,c,d} = idx still driven; busy = 1.
  - At the edge, truth_table[idx] <= f_in.
  - If f_in != EXPECTED_MASK[idx]: mismatch_count += 1; first_mismatch <= idx if it is the first mismatch or idx is lower than the stored value.
  - If the last vector: go to DONE; otherwise advance idx and go to SETTLE.
- Vector timing: each vector window is SETTLE_CYCLES+1 cycles; f_in is sampled at the edge ending the window.
- DONE: one cycle; done = 1, busy = 0, result_valid <= 1, pass computed from the final table; then back to IDLE.
- Latency: busy is high for exactly 16*(SETTLE_CYCLES+1) cycles; done follows in the next cycle.
- Results hold until the next accepted start or reset.
- start while busy or in DONE: ignored, no queuing.
- abort in SETTLE/SAMPLE: next state IDLE; result_valid stays 0; partial results are don't-care; no done pulse. abort in IDLE/DONE: no effect.
- abort and start high together in IDLE: start wins.
- Reset mid-scan: immediate return to the reset state; no done pulse.
- mismatch_count saturates naturally at 16 (5-bit); no overflow is possible.

Optional Feature:
- Macro SCAN_GRAY_EN.
- Defined: scan order is 4-bit Gray code (0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8), so exactly one stimulus bit toggles per step.
  - truth_table, comparison and first_mismatch remain indexed by minterm number, not scan position.
  - Last vector is minterm 8; timing is unchanged.
- Undefined: ascending binary order 0..15; last vector is minterm 15.

Test Plan:
- Function model with mask 16'hDF03, SETTLE_CYCLES=1, pulse start → busy for 32 cycles, done 1 cycle, truth_table=16'hDF03, pass=1, mismatch_count=0, first_mismatch=0, result_valid=1.
- f_in tied 0 → truth_table=16'h0000, pass=0, mismatch_count=9, first_mismatch=0; f_in tied 1 → truth_table=16'hFFFF, mismatch_count=7, first_mismatch=2.
- Model with minterm 13 flipped to 1 → truth_table=16'hFF03, mismatch_count=1, first_mismatch=13, pass=0.
- start held high throughout → one scan per IDLE visit; a second scan begins the cycle after the DONE cycle; vector sequence restarts at 0.
- abort while vector 7 is driven → next cycle IDLE, a/b/c/d=0, busy=0, no done, result_valid=0; rst_n low during vector 4 → all outputs 0 without waiting for a clock edge.
- SCAN_GRAY_EN defined, mask model 16'hDF03 → stimulus sequence matches Gray order with one bit change per step; truth_table=16'hDF03, pass=1.
